// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle control unit: state codes, ALU/cmd/Op codes, mux selects.
package multicycle_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRd    = 4'd3,
    StMemWb    = 4'd4,
    StMemWr    = 4'd5,
    StExecuteR = 4'd6,
    StExecuteI = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALU    = 1'b1;
  localparam logic [1:0] SRCA_RD1   = 2'b00;
  localparam logic [1:0] SRCA_PC    = 2'b01;
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Commands the datapath implements; anything else retires as a no-op.
  function automatic logic cmd_supported(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_AND) ||
           (cmd == CMD_ORR) || (cmd == CMD_CMP);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_alu_op_decoder.sv
// ALU decode for the data-processing states; keeps NoWrite asserted through ALUWB.
module alu_op_decoder
  import multicycle_pkg::*;
(
  input  logic       alu_op,
  input  logic [4:0] funct,     // cmd and S only; the I bit is consumed by the FSM
  input  logic       in_aluwb,
  output logic [1:0] alu_control,
  output logic [1:0] flag_w,
  output logic       no_write
);

  logic [3:0] cmd;
  logic       s_bit;
  logic       suppress;

  assign cmd      = funct[4:1];
  assign s_bit    = funct[0];
  assign suppress = (cmd == CMD_CMP) || !cmd_supported(cmd);

  always_comb begin
    alu_control = ALU_ADD;
    flag_w      = 2'b00;
    no_write    = 1'b0;
    if (alu_op) begin
      case (cmd)
        CMD_ADD: begin
          alu_control = ALU_ADD;
          flag_w      = s_bit ? 2'b11 : 2'b00;
        end
        CMD_SUB: begin
          alu_control = ALU_SUB;
          flag_w      = s_bit ? 2'b11 : 2'b00;
        end
        CMD_AND: begin
          alu_control = ALU_AND;
          flag_w      = s_bit ? 2'b10 : 2'b00;
        end
        CMD_ORR: begin
          alu_control = ALU_ORR;
          flag_w      = s_bit ? 2'b10 : 2'b00;
        end
        CMD_CMP: begin
          alu_control = ALU_SUB;
          flag_w      = 2'b11;
          no_write    = 1'b1;
        end
        default: no_write = 1'b1;
      endcase
    end else if (in_aluwb) begin
      no_write = suppress;
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle instruction sequencer: Moore FSM driving datapath selects and control requests.
module multicycle_control_fsm
  import multicycle_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] FlagW,
  output logic       NoWrite,
  output logic       NextPC,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc
);

  state_t state_q;
  logic   alu_op;
  logic   branch;
  logic   in_aluwb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      case (state_q)
        StFetch:  state_q <= StDecode;
        StDecode: begin
          case (Op)
            OP_MEM:  state_q <= StMemAdr;
            OP_DP:   state_q <= Funct[5] ? StExecuteI : StExecuteR;
            OP_BR:   state_q <= StBranch;
            default: state_q <= StFetch;
          endcase
        end
        StMemAdr:   state_q <= Funct[0] ? StMemRd : StMemWr;
        StMemRd:    state_q <= StMemWb;
        StExecuteR: state_q <= StAluWb;
        StExecuteI: state_q <= StAluWb;
        default:    state_q <= StFetch;
      endcase
    end
  end

  always_comb begin
    RegW      = 1'b0;
    MemW      = 1'b0;
    NextPC    = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = ADR_PC;
    ALUSrcA   = SRCA_RD1;
    ALUSrcB   = SRCB_RD2;
    ResultSrc = RES_ALUOUT;
    alu_op    = 1'b0;
    branch    = 1'b0;
    case (state_q)
      StFetch: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      StDecode: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      StMemAdr: ALUSrcB = SRCB_IMM;
      StMemRd:  AdrSrc = ADR_ALU;
      StMemWb: begin
        ResultSrc = RES_DATA;
        RegW      = 1'b1;
      end
      StMemWr: begin
        AdrSrc = ADR_ALU;
        MemW   = 1'b1;
      end
      StExecuteR: alu_op = 1'b1;
      StExecuteI: begin
        ALUSrcB = SRCB_IMM;
        alu_op  = 1'b1;
      end
      StAluWb: RegW = 1'b1;
      StBranch: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALU;
        branch    = 1'b1;
      end
      default: ;
    endcase
    PCS = ((Rd == 4'd15) && RegW) || branch;
  end

  assign in_aluwb = (state_q == StAluWb);
  assign ImmSrc   = Op;
  assign RegSrc   = {Op == OP_MEM, Op == OP_BR};

  alu_op_decoder u_alu_op_decoder (
    .alu_op      (alu_op),
    .funct       (Funct[4:0]),
    .in_aluwb    (in_aluwb),
    .alu_control (ALUControl),
    .flag_w      (FlagW),
    .no_write    (NoWrite)
  );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench: per-instruction state trace and per-state outputs from a behavioural model.
module tb_multicycle_control_fsm;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       PCS, RegW, MemW, NoWrite, NextPC, IRWrite, AdrSrc;
  logic [1:0] FlagW, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc;
  logic [20:0] obs;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_control_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .PCS        (PCS),
    .RegW       (RegW),
    .MemW       (MemW),
    .FlagW      (FlagW),
    .NoWrite    (NoWrite),
    .NextPC     (NextPC),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc)
  );

  assign obs = {PCS, RegW, MemW, FlagW, NoWrite, NextPC, IRWrite, AdrSrc,
                ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sequence of state codes an instruction walks through, starting at FETCH.
  function automatic void build_trace(input logic [1:0] op, input logic [5:0] funct,
                                      output int tr[$]);
    tr = {};
    tr.push_back(0);
    tr.push_back(1);
    case (op)
      2'b01: begin
        tr.push_back(2);
        if (funct[0]) begin
          tr.push_back(3);
          tr.push_back(4);
        end else begin
          tr.push_back(5);
        end
      end
      2'b00: begin
        tr.push_back(funct[5] ? 7 : 6);
        tr.push_back(8);
      end
      2'b10: tr.push_back(9);
      default: ;
    endcase
  endfunction

  function automatic logic [20:0] model_out(input int st, input logic [1:0] op,
                                            input logic [5:0] funct, input logic [3:0] rd);
    logic regw, memw, nw, nextpc, irw, adr, br, alu, pcs, known, is_cmp;
    logic [1:0] fw, srca, srcb, res, ctl;
    logic [3:0] cmd;
    {regw, memw, nw, nextpc, irw, adr, br, alu} = '0;
    {fw, srca, srcb, res, ctl} = '0;
    case (st)
      0: begin irw = 1; nextpc = 1; srca = 2'd1; srcb = 2'd2; res = 2'd2; end
      1: begin srca = 2'd1; srcb = 2'd2; res = 2'd2; end
      2: srcb = 2'd1;
      3: adr = 1;
      4: begin res = 2'd1; regw = 1; end
      5: begin adr = 1; memw = 1; end
      6: alu = 1;
      7: begin srcb = 2'd1; alu = 1; end
      8: regw = 1;
      9: begin srcb = 2'd1; res = 2'd2; br = 1; end
      default: ;
    endcase
    cmd    = funct[4:1];
    is_cmp = (cmd == 4'b1010);
    known  = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b0000) ||
             (cmd == 4'b1100) || is_cmp;
    if (alu) begin
      if (cmd == 4'b0010 || is_cmp) ctl = 2'd1;
      else if (cmd == 4'b0000)      ctl = 2'd2;
      else if (cmd == 4'b1100)      ctl = 2'd3;
      if (is_cmp) fw = 2'b11;
      else if (known && funct[0]) fw = (cmd == 4'b0100 || cmd == 4'b0010) ? 2'b11 : 2'b10;
      nw = !known || is_cmp;
    end
    if (st == 8) nw = !known || is_cmp;
    pcs = (regw && rd == 4'd15) || br;
    return {pcs, regw, memw, fw, nw, nextpc, irw, adr, srca, srcb, res, ctl, op,
            op == 2'b01, op == 2'b10};
  endfunction

  // Called mid-cycle with the DUT in FETCH; returns mid-cycle at the next FETCH.
  task automatic run_instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd);
    int tr[$];
    Op = op;
    Funct = funct;
    Rd = rd;
    build_trace(op, funct, tr);
    foreach (tr[k]) begin
      #1;
      check_eq($sformatf("state op=%0d f=%0h k=%0d", op, funct, k), 32'(dut.state_q), tr[k]);
      check_eq($sformatf("outs op=%0d f=%0h rd=%0d st=%0d", op, funct, rd, tr[k]),
               32'(obs), 32'(model_out(tr[k], op, funct, rd)));
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    Op = 2'b00;
    Funct = 6'b0;
    Rd = 4'd0;
    #1;
    check_eq("reset state", 32'(dut.state_q), 0);
    check_eq("reset outs", 32'(obs), 32'(model_out(0, 2'b00, 6'b0, 4'd0)));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_instr(2'b01, 6'b011001, 4'd2);   // LDR
    run_instr(2'b01, 6'b011000, 4'd15);  // STR
    run_instr(2'b00, 6'b001001, 4'd3);   // ADDS reg
    run_instr(2'b00, 6'b110101, 4'd0);   // CMP imm
    run_instr(2'b00, 6'b011000, 4'd15);  // ORR S=0 to PC
    run_instr(2'b10, 6'b000000, 4'd0);   // B
    run_instr(2'b11, 6'b001001, 4'd15);  // illegal Op

    // Asynchronous reset landing in MEMRD of a load.
    Op = 2'b01;
    Funct = 6'b011001;
    Rd = 4'd4;
    for (int k = 0; k < 3; k++) @(negedge clk);
    #1;
    check_eq("pre-reset memrd", 32'(dut.state_q), 3);
    reset = 1'b1;
    #1;
    check_eq("async reset state", 32'(dut.state_q), 0);
    check_eq("async reset outs", 32'(obs), 32'(model_out(0, 2'b01, 6'b011001, 4'd4)));
    check_eq("async reset irwrite", 32'(IRWrite), 1);
    check_eq("async reset nextpc", 32'(NextPC), 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("held reset state", 32'(dut.state_q), 0);
    @(negedge clk);
    #1;
    check_eq("post-release decode", 32'(dut.state_q), 1);
    for (int k = 0; k < 4; k++) @(negedge clk);  // finish DECODE..MEMWB
    #1;
    check_eq("post-release back to fetch", 32'(dut.state_q), 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    reset = 1'b0;

    for (int i = 0; i < 150; i++) begin
      logic [1:0] op;
      logic [5:0] funct;
      logic [3:0] rd;
      logic [3:0] cmds [5];
      cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000;
      cmds[3] = 4'b1100; cmds[4] = 4'b1010;
      op    = 2'($urandom_range(0, 3));
      funct = 6'($urandom);
      if ($urandom_range(0, 3) != 0) funct[4:1] = cmds[$urandom_range(0, 4)];
      rd    = ($urandom_range(0, 2) == 0) ? 4'd15 : 4'($urandom);
      run_instr(op, funct, rd);
    end
    #1;
    check_eq("final fetch", 32'(dut.state_q), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
